// File: rtl/avalon_pio_pulse_out_pkg.sv
// Shared definitions for the pulse-capable Avalon PIO output port:
// register offsets, status/control bit positions and pulse FSM encoding.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
  localparam logic [2:0] ADDR_SET       = 3'd2;
  localparam logic [2:0] ADDR_CLEAR     = 3'd3;
  localparam logic [2:0] ADDR_PULSE     = 3'd4;
  localparam logic [2:0] ADDR_STATUS    = 3'd5;
  localparam logic [2:0] ADDR_COUNT     = 3'd6;
  localparam logic [2:0] ADDR_CTRL      = 3'd7;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT = 0;

  typedef enum logic {
    PULSE_IDLE   = 1'b0,
    PULSE_ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/avalon_pio_pulse_out_if.sv
// Avalon-MM slave bus bundle for the pulse PIO (zero-latency reads, no wait states).
interface avalon_pio_pulse_out_if;
  import avalon_pio_pkg::*;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/avalon_pio_pulse_out_timer.sv
// Pulse length timer: counts a loaded length down to zero and flags the final edge.
// A load while active restarts the count without reporting completion.
module pio_pulse_timer
  import avalon_pio_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 busy_next,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 done_pulse
);

  pulse_state_e         state_r, state_next_s;
  logic [CNT_WIDTH-1:0] count_r, count_next_s;

  // State and remaining-cycle registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= PULSE_IDLE;
      count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
    end
  end

  // Next-state logic: load wins over expiry so a restart never reports DONE
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    done_pulse   = 1'b0;
    case (state_r)
      PULSE_IDLE: begin
        if (load) begin
          state_next_s = PULSE_ACTIVE;
          count_next_s = len;
        end else begin
          state_next_s = PULSE_IDLE;
          count_next_s = {CNT_WIDTH{1'b0}};
        end
      end
      PULSE_ACTIVE: begin
        if (load) begin
          count_next_s = len;
        end else if (count_r == CNT_WIDTH'(1)) begin
          state_next_s = PULSE_IDLE;
          count_next_s = {CNT_WIDTH{1'b0}};
          done_pulse   = 1'b1;
        end else begin
          count_next_s = count_r - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_next_s = PULSE_IDLE;
        count_next_s = {CNT_WIDTH{1'b0}};
      end
    endcase
  end

  assign busy      = (state_r == PULSE_ACTIVE);
  assign busy_next = (state_next_s == PULSE_ACTIVE);
  assign count     = count_r;

endmodule

// File: rtl/avalon_pio_pulse_out.sv
// Avalon-MM PIO output port with atomic set/clear and hardware-timed pulses.
// out_port is registered from next-state DATA/MASK/busy so writes show right after their edge.
module avalon_pio_pulse_out
  import avalon_pio_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}},
  parameter int               CNT_WIDTH     = 16,
  parameter int               DEF_PULSE_LEN = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  avalon_pio_pulse_out_if.slave bus,
  output logic [WIDTH-1:0]      out_port,
  output logic                  pulse_busy,
  output logic                  irq
);

  logic [WIDTH-1:0]     data_r, mask_r, out_port_r;
  logic [CNT_WIDTH-1:0] plen_r;
  logic                 done_r, irq_en_r, irq_r;

  logic [WIDTH-1:0]     data_next_s, mask_wr_s, mask_next_s, wd_data_s;
  logic [CNT_WIDTH-1:0] plen_next_s, wd_cnt_s, count_s;
  logic                 done_wr_s, done_next_s, irq_en_next_s;
  logic                 wr_s, load_s, busy_s, busy_next_s, done_pulse_s;
  logic [31:0]          rdata_s;
  logic                 unused_writedata_s;

  assign wr_s      = bus.chipselect & ~bus.write_n;
  assign wd_data_s = bus.writedata[WIDTH-1:0];
  assign wd_cnt_s  = bus.writedata[CNT_WIDTH-1:0];
  assign unused_writedata_s = ^bus.writedata;

  // A pulse with an empty mask or zero length is dropped entirely
  assign load_s = wr_s && (bus.address == ADDR_PULSE) &&
                  (wd_data_s != {WIDTH{1'b0}}) && (plen_r != {CNT_WIDTH{1'b0}});

  pio_pulse_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load_s),
    .len        (plen_r),
    .busy       (busy_s),
    .busy_next  (busy_next_s),
    .count      (count_s),
    .done_pulse (done_pulse_s)
  );

  // Register write decode
  always_comb begin
    data_next_s   = data_r;
    plen_next_s   = plen_r;
    mask_wr_s     = mask_r;
    done_wr_s     = done_r;
    irq_en_next_s = irq_en_r;
    if (wr_s) begin
      case (bus.address)
        ADDR_DATA:      data_next_s   = wd_data_s;
        ADDR_PULSE_LEN: plen_next_s   = wd_cnt_s;
        ADDR_SET:       data_next_s   = data_r | wd_data_s;
        ADDR_CLEAR:     data_next_s   = data_r & ~wd_data_s;
        ADDR_PULSE: begin
          if (load_s) begin
            mask_wr_s = wd_data_s;
          end else begin
            mask_wr_s = mask_r;
          end
        end
        ADDR_STATUS:    done_wr_s     = done_r & ~bus.writedata[STATUS_DONE_BIT];
        ADDR_CTRL:      irq_en_next_s = bus.writedata[CTRL_IRQ_EN_BIT];
        default:        data_next_s   = data_r;
      endcase
    end else begin
      data_next_s = data_r;
    end
  end

  // Expiry clears the mask and sets DONE, overriding a same-edge W1C
  assign mask_next_s = done_pulse_s ? {WIDTH{1'b0}} : mask_wr_s;
  assign done_next_s = done_pulse_s | done_wr_s;

  // Architectural registers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r     <= RESET_VALUE;
      plen_r     <= CNT_WIDTH'(DEF_PULSE_LEN);
      mask_r     <= {WIDTH{1'b0}};
      done_r     <= 1'b0;
      irq_en_r   <= 1'b0;
      out_port_r <= RESET_VALUE;
      irq_r      <= 1'b0;
    end else begin
      data_r     <= data_next_s;
      plen_r     <= plen_next_s;
      mask_r     <= mask_next_s;
      done_r     <= done_next_s;
      irq_en_r   <= irq_en_next_s;
      out_port_r <= data_next_s ^ (busy_next_s ? mask_next_s : {WIDTH{1'b0}});
      irq_r      <= done_next_s & irq_en_next_s;
    end
  end

  // Zero-latency read mux, zero-extended
  always_comb begin
    rdata_s = 32'd0;
    case (bus.address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR: rdata_s[WIDTH-1:0] = data_r;
      ADDR_PULSE_LEN: rdata_s[CNT_WIDTH-1:0] = plen_r;
      ADDR_PULSE:     rdata_s[WIDTH-1:0]     = mask_r;
      ADDR_STATUS: begin
        rdata_s[STATUS_DONE_BIT] = done_r;
        rdata_s[STATUS_BUSY_BIT] = busy_s;
      end
      ADDR_COUNT:     rdata_s[CNT_WIDTH-1:0] = count_s;
      ADDR_CTRL:      rdata_s[CTRL_IRQ_EN_BIT] = irq_en_r;
      default:        rdata_s = 32'd0;
    endcase
  end

  assign bus.readdata = rdata_s;
  assign out_port     = out_port_r;
  assign pulse_busy   = busy_s;
  assign irq          = irq_r;

endmodule
